// File: rtl/grf_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port.
// Channel 0 is the main pipeline and channel 1 the mul/div unit; the winner is registered onto the port.
module grf_wb_arbiter #(
   parameter int unsigned AW = 5,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wb_stall,
   input  logic          v0,
   input  logic [AW-1:0] a0,
   input  logic [DW-1:0] d0,
   input  logic [DW-1:0] pc0,
   output logic          r0,
   input  logic          v1,
   input  logic [AW-1:0] a1,
   input  logic [DW-1:0] d1,
   input  logic [DW-1:0] pc1,
   output logic          r1,
   output logic          we,
   output logic [AW-1:0] a3,
   output logic [DW-1:0] wd3,
   output logic [DW-1:0] wpc,
   output logic          gnt_id
);

   logic prio_q, prio_d;
   logic xfer;

   // Grants are mutually exclusive; a tie goes to the channel named by prio_q.
   always_comb begin
      r0 = 1'b0;
      r1 = 1'b0;
      if (!reset && !wb_stall) begin
         if (v0 && (!v1 || !prio_q)) begin
            r0 = 1'b1;
         end else if (v1) begin
            r1 = 1'b1;
         end
      end
   end

   assign xfer = r0 | r1;

   always_comb begin
      prio_d = prio_q;
      if (xfer) begin
         prio_d = ~r1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q <= 1'b0;
         we     <= 1'b0;
         a3     <= '0;
         wd3    <= '0;
         wpc    <= '0;
         gnt_id <= 1'b0;
      end else begin
         prio_q <= prio_d;
         we     <= xfer;
         // Address, data and pc hold their last value when no write happens.
         if (xfer) begin
            a3     <= r1 ? a1 : a0;
            wd3    <= r1 ? d1 : d0;
            wpc    <= r1 ? pc1 : pc0;
            gnt_id <= r1;
         end
      end
   end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed table-driven bench for grf_wb_arbiter plus a hand-written reset-mid-operation sequence.
module tb_grf_wb_arbiter;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic          clk;
   logic          reset;
   logic          wb_stall;
   logic          v0, v1;
   logic [AW-1:0] a0, a1;
   logic [DW-1:0] d0, d1, pc0, pc1;
   logic          r0, r1;
   logic          we;
   logic [AW-1:0] a3;
   logic [DW-1:0] wd3, wpc;
   logic          gnt_id;

   int n_cmp = 0;
   int n_err = 0;

   grf_wb_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .wb_stall (wb_stall),
      .v0       (v0),
      .a0       (a0),
      .d0       (d0),
      .pc0      (pc0),
      .r0       (r0),
      .v1       (v1),
      .a1       (a1),
      .d1       (d1),
      .pc1      (pc1),
      .r1       (r1),
      .we       (we),
      .a3       (a3),
      .wd3      (wd3),
      .wpc      (wpc),
      .gnt_id   (gnt_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          stl;
      logic          v0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic [DW-1:0] pc0;
      logic          v1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic [DW-1:0] pc1;
      logic          er0;
      logic          er1;
      logic          ewe;
      logic [AW-1:0] ea3;
      logic [DW-1:0] ewd;
      logic [DW-1:0] ewpc;
      logic          egnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic stl,
                      input logic iv0, input logic [AW-1:0] ia0, input logic [DW-1:0] id0,
                      input logic [DW-1:0] ipc0,
                      input logic iv1, input logic [AW-1:0] ia1, input logic [DW-1:0] id1,
                      input logic [DW-1:0] ipc1,
                      input logic er0, input logic er1, input logic ewe,
                      input logic [AW-1:0] ea3, input logic [DW-1:0] ewd,
                      input logic [DW-1:0] ewpc, input logic egnt);
      vec_t v;
      v.rst = rst;  v.stl = stl;
      v.v0 = iv0;   v.a0 = ia0;  v.d0 = id0;  v.pc0 = ipc0;
      v.v1 = iv1;   v.a1 = ia1;  v.d1 = id1;  v.pc1 = ipc1;
      v.er0 = er0;  v.er1 = er1; v.ewe = ewe; v.ea3 = ea3;
      v.ewd = ewd;  v.ewpc = ewpc; v.egnt = egnt;
      vecs.push_back(v);
   endtask

   task automatic chk(input int idx, input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL step %0d %s: got %0h, expected %0h", idx, name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic stl,
                        input logic iv0, input logic [AW-1:0] ia0, input logic [DW-1:0] id0,
                        input logic [DW-1:0] ipc0,
                        input logic iv1, input logic [AW-1:0] ia1, input logic [DW-1:0] id1,
                        input logic [DW-1:0] ipc1);
      reset = rst; wb_stall = stl;
      v0 = iv0; a0 = ia0; d0 = id0; pc0 = ipc0;
      v1 = iv1; a1 = ia1; d1 = id1; pc1 = ipc1;
   endtask

   task automatic chk_out(input int idx, input logic ewe, input logic [AW-1:0] ea3,
                          input logic [DW-1:0] ewd, input logic [DW-1:0] ewpc,
                          input logic egnt);
      chk(idx, "we",     32'(we),     32'(ewe));
      chk(idx, "a3",     32'(a3),     32'(ea3));
      chk(idx, "wd3",    32'(wd3),    32'(ewd));
      chk(idx, "wpc",    32'(wpc),    32'(ewpc));
      chk(idx, "gnt_id", 32'(gnt_id), 32'(egnt));
   endtask

   initial begin
      // rst stl  v0 a0  d0            pc0        v1 a1  d1     pc1     r0 r1 we a3  wd3           wpc       gnt
      add(1, 0,   1, 1,  32'h11,       32'h100,   1, 2,  32'h22, 32'h200, 0, 0, 0, 0,  32'h0,        32'h0,    0);
      add(1, 0,   1, 1,  32'h11,       32'h100,   1, 2,  32'h22, 32'h200, 0, 0, 0, 0,  32'h0,        32'h0,    0);
      // contention: alternate 0,1,0,1 with no bubble
      add(0, 0,   1, 1,  32'h11,       32'h100,   1, 2,  32'h22, 32'h200, 1, 0, 1, 1,  32'h11,       32'h100,  0);
      add(0, 0,   1, 1,  32'h11,       32'h100,   1, 2,  32'h22, 32'h200, 0, 1, 1, 2,  32'h22,       32'h200,  1);
      add(0, 0,   1, 1,  32'h11,       32'h100,   1, 2,  32'h22, 32'h200, 1, 0, 1, 1,  32'h11,       32'h100,  0);
      add(0, 0,   1, 1,  32'h11,       32'h100,   1, 2,  32'h22, 32'h200, 0, 1, 1, 2,  32'h22,       32'h200,  1);
      add(0, 0,   0, 0,  32'h0,        32'h0,     0, 0,  32'h0,  32'h0,   0, 0, 0, 2,  32'h22,       32'h200,  1);
      // single channel 0
      add(0, 0,   1, 5,  32'h12345678, 32'h3000,  0, 0,  32'h0,  32'h0,   1, 0, 1, 5,  32'h12345678, 32'h3000, 0);
      add(0, 0,   0, 0,  32'h0,        32'h0,     0, 0,  32'h0,  32'h0,   0, 0, 0, 5,  32'h12345678, 32'h3000, 0);
      // only channel 1, including while prio points at channel 0
      add(0, 0,   0, 0,  32'h0,        32'h0,     1, 9,  32'h99, 32'h900, 0, 1, 1, 9,  32'h99,       32'h900,  1);
      add(0, 0,   0, 0,  32'h0,        32'h0,     1, 10, 32'hA0, 32'hA00, 0, 1, 1, 10, 32'hA0,       32'hA00,  1);
      // stall: registered write completes, then nothing granted for 3 cycles
      add(0, 0,   1, 3,  32'h33,       32'h300,   0, 0,  32'h0,  32'h0,   1, 0, 1, 3,  32'h33,       32'h300,  0);
      add(0, 1,   1, 1,  32'h11,       32'h100,   1, 2,  32'h22, 32'h200, 0, 0, 0, 3,  32'h33,       32'h300,  0);
      add(0, 1,   1, 1,  32'h11,       32'h100,   1, 2,  32'h22, 32'h200, 0, 0, 0, 3,  32'h33,       32'h300,  0);
      add(0, 1,   1, 1,  32'h11,       32'h100,   1, 2,  32'h22, 32'h200, 0, 0, 0, 3,  32'h33,       32'h300,  0);
      add(0, 0,   1, 1,  32'h11,       32'h100,   1, 2,  32'h22, 32'h200, 0, 1, 1, 2,  32'h22,       32'h200,  1);
      add(0, 0,   1, 1,  32'h11,       32'h100,   0, 0,  32'h0,  32'h0,   1, 0, 1, 1,  32'h11,       32'h100,  0);
      // register $0 is emitted unchanged
      add(0, 0,   1, 0,  32'hFFFFFFFF, 32'h400,   0, 0,  32'h0,  32'h0,   1, 0, 1, 0,  32'hFFFFFFFF, 32'h400,  0);
      // same destination from both: two writes in prio order
      add(0, 0,   1, 7,  32'hAA,       32'h500,   1, 7,  32'hBB, 32'h600, 0, 1, 1, 7,  32'hBB,       32'h600,  1);
      add(0, 0,   1, 7,  32'hAA,       32'h500,   0, 0,  32'h0,  32'h0,   1, 0, 1, 7,  32'hAA,       32'h500,  0);
      add(0, 0,   0, 0,  32'h0,        32'h0,     0, 0,  32'h0,  32'h0,   0, 0, 0, 7,  32'hAA,       32'h500,  0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].stl, vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].pc0,
               vecs[i].v1, vecs[i].a1, vecs[i].d1, vecs[i].pc1);
         #1;
         chk(i, "r0", 32'(r0), 32'(vecs[i].er0));
         chk(i, "r1", 32'(r1), 32'(vecs[i].er1));
         @(posedge clk);
         #1;
         chk_out(i, vecs[i].ewe, vecs[i].ea3, vecs[i].ewd, vecs[i].ewpc, vecs[i].egnt);
      end

      // Reset mid-operation; prio is 1 here, so the first tie after reset exposes its clearing.
      drive(0, 0, 1, 12, 32'hC0, 32'hC00, 0, 0, 32'h0, 32'h0);
      #1;
      chk(100, "r0", 32'(r0), 32'(1'b1));
      @(posedge clk);
      #1;
      chk_out(100, 1'b1, 5'd12, 32'hC0, 32'hC00, 1'b0);
      drive(1, 0, 1, 13, 32'hD0, 32'hD00, 1, 14, 32'hE0, 32'hE00);
      #1;
      chk(101, "r0", 32'(r0), 32'(1'b0));
      chk(101, "r1", 32'(r1), 32'(1'b0));
      @(posedge clk);
      #1;
      chk_out(101, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
      drive(0, 0, 1, 13, 32'hD0, 32'hD00, 1, 14, 32'hE0, 32'hE00);
      #1;
      chk(102, "r0", 32'(r0), 32'(1'b1));
      chk(102, "r1", 32'(r1), 32'(1'b0));
      @(posedge clk);
      #1;
      chk_out(102, 1'b1, 5'd13, 32'hD0, 32'hD00, 1'b0);

      // Channel 1 held high must be granted within 2 cycles.
      drive(0, 0, 1, 15, 32'hF0, 32'hF00, 1, 16, 32'h160, 32'h1600);
      begin
         int waited;
         waited = 0;
         #1;
         while (!r1 && waited < 2) begin
            @(posedge clk);
            #1;
            waited++;
         end
         chk(103, "r1_within_2", 32'(r1), 32'(1'b1));
         @(posedge clk);
         #1;
         chk_out(103, 1'b1, 5'd16, 32'h160, 32'h1600, 1'b1);
      end

      drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      chk(104, "we_idle", 32'(we), 32'(1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Shares the single write port of the general register file between two write-back requesters.
  - Channel 0 is the main pipeline write-back.
  - Channel 1 is the multi-cycle multiply/divide unit.
- Selects one request per cycle using valid/ready handshakes with round-robin fairness.
- Registers the winner onto the register file write port (write enable, write address, write data, pc) one cycle later.
- Sits directly in front of the register file, so the register-file write log is fed by exactly one source per cycle.

Parameters:
- AW, 5, register address width.
- DW, 32, write data width and pc width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wb_stall  input  1  when 1, no grant is issued this cycle.
- v0  input  1  channel 0 request valid.
- a0  input  AW  channel 0 destination register.
- d0  input  DW  channel 0 write data.
- pc0  input  DW  channel 0 instruction pc.
- r0  output  1  channel 0 ready (grant); combinational.
- v1  input  1  channel 1 request valid.
- a1  input  AW  channel 1 destination register.
- d1  input  DW  channel 1 write data.
- pc1  input  DW  channel 1 instruction pc.
- r1  output  1  channel 1 ready (grant); combinational.
- we  output  1  register file write enable; registered.
- a3  output  AW  register file write address; registered.
- wd3  output  DW  register file write data; registered.
- wpc  output  DW  pc of the write being performed; registered.
- gnt_id  output  1  channel that produced the current we pulse; registered.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high and is sampled only on the rising edge of clk.
- Reset values (next edge with reset=1):
  - we=0, a3=0, wd3=0, wpc=0, gnt_id=0.
  - Priority pointer prio=0, meaning channel 0 wins the next tie.
- r0/r1 during reset: forced to 0 while reset=1.
- Handshake: a transfer on channel k occurs in a cycle where vk=1 and rk=1.
  - The requester must hold vk, ak, dk and pck stable until the transfer.
  - The requester may not drop vk before the transfer.
- Grant logic (combinational, at most one of r0/r1 high):
  - wb_stall=1 or reset=1: r0=r1=0.
  - Only v0=1: r0=1.
  - Only v1=1: r1=1.
  - Both valid: the channel equal to prio wins.
- Pointer update: on a transfer by channel k, prio <= ~k on the next edge. With no transfer, prio holds.
  - A channel with vk held high is therefore granted within 2 cycles when wb_stall=0.
- Output stage, every rising edge when reset=0:
  - Transfer by channel k: we<=1, a3<=ak, wd3<=dk, wpc<=pck, gnt_id<=k.
  - No transfer: we<=0; a3, wd3, wpc and gnt_id hold their previous values.
- Latency: exactly 1 cycle from transfer to we=1. Throughput: 1 write per cycle, with no bubble between back-to-back grants.
- Register $0: requests with ak=0 are granted and emitted unchanged (we=1, a3=0). The register file discards the write but still logs it.
- Same destination from both channels: serialized in round-robin order, no merging. The later grant is the later write.
- wb_stall rising while a request is pending:
  - The request is not granted and stays pending.
  - A write already registered on the output still completes this cycle.
- Reset mid-operation:
  - Any pending un-granted request is not remembered; the requester is expected to be reset too.
  - An output-stage write registered before the reset edge is visible for its one cycle; the reset edge then clears we.

Test Plan:
- Reset: reset=1 for 2 cycles with v0=v1=1 -> r0=r1=0 during reset; we=0, a3=0, wd3=0, wpc=0 after release; the first tie is granted to channel 0.
- Single channel: v0=1, a0=5, d0=0x12345678, pc0=0x00003000 for 1 cycle -> r0=1 that cycle; next cycle we=1, a3=5, wd3=0x12345678, wpc=0x00003000, gnt_id=0; the following cycle we=0.
- Contention: v0 and v1 held high for 4 cycles with distinct addresses (a0=1, a1=2) -> grants alternate 0,1,0,1; we stays high for 4 consecutive cycles with a3 sequence 1,2,1,2.
- Stall: both valid, wb_stall=1 for 3 cycles, then 0 -> no r0/r1 and we=0 during the stall (except a write already registered); after release, grant goes to prio with no request lost.
- Register $0 and same destination: v0 with a0=0, d0=0xFFFFFFFF -> we=1, a3=0 emitted. Then both channels target a3=7 with d0=0xAA and d1=0xBB -> two separate writes, ordered by prio.
- Reset mid-operation: assert reset the cycle after a grant -> the granted write appears for one cycle, then we=0; prio returns to 0.
